datapath_pack_fifo: RTL
=======================

# datapath_pack_fifo

Parametrised width-converting FIFO for the driver datapath. It packs PACK consecutive IN_W-bit input beats into one OUT_W = IN_W*PACK-bit entry, and stores up to 2^DEPTH_LOG2 entries. Entries are released on a rate-limited read strobe (one read opportunity every CLK_DIV cycles), which paces the downstream serialiser. It also provides an exact occupancy count, a programmable threshold, selectable beat order, synchronous flush and sticky error flags.

## Interface
- IN_W, 64, input beat width in bits.
- PACK, 3, input beats per stored entry (≥1); OUT_W = IN_W*PACK is a derived localparam.
- DEPTH_LOG2, 10, log2 of entry capacity (DEPTH = 2^DEPTH_LOG2).
- CLK_DIV, 30, read-opportunity period in clk cycles (≥1).
- THRESH, 512, threshold level in entries (1..DEPTH).
- BEAT_MSB_FIRST, 0, 0: beat 0 goes to bits [IN_W-1:0]; 1: beat 0 goes to the top slice.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, synchronous, active-low.
- flush  in  1  synchronous clear of FIFO contents and flags.
- wr  in  1  input beat strobe.
- data_in  in  IN_W  input beat.
- rd  in  1  read request, sampled on read ticks only.
- data_out  out  OUT_W  last read entry, registered, held between reads.
- rd_valid  out  1  one-cycle pulse in the cycle data_out updates.
- data_count  out  DEPTH_LOG2+1  committed entries, 0..DEPTH.
- partial  out  1  high when a partially assembled entry is pending (beat counter ≠ 0).
- full, empty, threshold  out  1  status flags.
- overflow, underflow  out  1  sticky error flags.

## Operation
- Pointers w_ptr and r_ptr are DEPTH_LOG2+1 bits wide and wrap naturally.
- data_count = w_ptr − r_ptr, taken modulo 2^(DEPTH_LOG2+1), combinational from registers.
- full = (data_count == DEPTH); empty = (data_count == 0); threshold = (data_count ≥ THRESH).
- Write path: accept = wr & ~full. The beat counter runs 0..PACK-1.
  - Beats 0..PACK-2 load their slice of an assembly register.
  - Beat PACK-1 commits {assembly, data_in}, ordered per BEAT_MSB_FIRST, into mem[w_ptr[DEPTH_LOG2-1:0]]; w_ptr increments and the beat counter returns to 0.
  - With PACK=1, every accepted beat commits.
- Read tick: counter 0..CLK_DIV-1; tick = (counter == CLK_DIV-1), after which the counter returns to 0. With CLK_DIV=1, tick is high every cycle.
  - The counter free-runs; flush does not reset it.
- Read path: rd_go = tick & rd & ~empty. On rd_go:
  - data_out ← mem[r_ptr[DEPTH_LOG2-1:0]];
  - r_ptr increments;
  - rd_valid is 1 in the next cycle.
- overflow: set on wr & full (the beat is dropped).
- underflow: set on tick & rd & empty.
- Both error flags clear only on reset or flush. Set has priority over flush in the same cycle.
- flush clears w_ptr, r_ptr, the beat counter and the assembly register. It does not change data_out or rd_valid, and it drops any partial entry.
- Reset clears everything: data_out=0, rd_valid=0, data_count=0, partial=0, full=0, empty=1, threshold=0, overflow=0, underflow=0.
- The memory array is not reset.

## Timing
- Write-to-count latency: the commit edge updates w_ptr, so data_count/empty/full change in the cycle after the final beat.
- Read latency: data_out and rd_valid update one cycle after the rd_go cycle; data_count drops in that same cycle.
- A commit and rd_go in the same cycle leave data_count unchanged. Neither is blocked, except that full blocks writes even when a read occurs that cycle (no bypass).
- Empty blocks reads, so there is no read of an entry that is committed in the same cycle.
- Back-to-back writes at 1 beat/cycle are accepted at full rate until full.
- Reads are limited to at most 1 per CLK_DIV cycles.
- Pointer wrap at DEPTH is seamless: the count stays exact across the MSB toggle.
- A reset or flush while the FIFO is partially filled takes effect on that edge; wr and rd on the same edge are ignored.

## Test plan
Bench parameters: IN_W=64, PACK=3, DEPTH_LOG2=2, CLK_DIV=4, THRESH=2.
- Pack order: write beats A,B,C (A=0x1…, B=0x2…, C=0x3…), then rd held high.
  - BEAT_MSB_FIRST=0: data_out={C,B,A}, rd_valid pulses once, and the pulse lands on a tick+1 cycle.
  - BEAT_MSB_FIRST=1: data_out={A,B,C}.
- Full/overflow: write 12 beats, then 1 more → data_count=4, full=1, overflow=1; the 13th beat is lost and a read returns entries 0..3 intact.
- Rate limit and wrap: keep rd high while writing 30 beats continuously → reads are spaced exactly 4 cycles apart, all 10 entries are returned in order, and data_count never exceeds 4 after the wrap.
- Underflow: rd high with the FIFO empty → underflow=1 on the first tick, and it stays 1 after later writes until flush.
- Partial then flush: write 2 beats → partial=1, data_count=0. Flush → partial=0 and overflow/underflow are cleared; a fresh 3-beat write then reads back with no stale beats.
- Threshold and reset: commit 2 entries → threshold=1. Assert rstn=0 for one cycle → every output returns to its reset value, and data_out=0.

Source files
------------

// File: rtl/datapath_pack_fifo_if.sv
// Bus between the driver datapath and the packing FIFO: beat writes in, paced entry reads out, status back.
interface datapath_pack_fifo_if #(
  parameter int IN_W       = 64,
  parameter int PACK       = 3,
  parameter int DEPTH_LOG2 = 10
);
  localparam int OUT_W = IN_W * PACK;

  logic                  flush;
  logic                  wr;
  logic [IN_W-1:0]       data_in;
  logic                  rd;
  logic [OUT_W-1:0]      data_out;
  logic                  rd_valid;
  logic [DEPTH_LOG2:0]   data_count;
  logic                  partial;
  logic                  full;
  logic                  empty;
  logic                  threshold;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr, data_in, rd,
    input  data_out, rd_valid, data_count, partial, full, empty, threshold, overflow, underflow
  );

  modport slave (
    input  flush, wr, data_in, rd,
    output data_out, rd_valid, data_count, partial, full, empty, threshold, overflow, underflow
  );
endinterface

// File: rtl/datapath_pack_fifo.sv
// Packs PACK input beats per entry; entries leave one cycle after a read tick (1 per CLK_DIV cycles).
// Full drops incoming beats (sticky overflow); reading while empty is ignored (sticky underflow).
module datapath_pack_fifo #(
  parameter int IN_W           = 64,
  parameter int PACK           = 3,
  parameter int DEPTH_LOG2     = 10,
  parameter int CLK_DIV        = 30,
  parameter int THRESH         = 512,
  parameter int BEAT_MSB_FIRST = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  datapath_pack_fifo_if.slave  bus
);
  localparam int OUT_W = IN_W * PACK;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BCW   = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int DCW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_C   = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] THRESH_C  = (DEPTH_LOG2+1)'(THRESH);
  localparam logic [BCW-1:0]      LAST_BEAT = BCW'(PACK - 1);
  localparam logic [DCW-1:0]      DIV_TOP   = DCW'(CLK_DIV - 1);

  logic [OUT_W-1:0]    mem [DEPTH];
  logic [DEPTH_LOG2:0] w_ptr, r_ptr, count;
  logic [BCW-1:0]      beat_cnt, slot;
  logic [DCW-1:0]      div_cnt;
  logic [OUT_W-1:0]    asm_q, asm_next, data_out_q;
  logic                rd_valid_q, ovf_q, unf_q;
  logic                full, empty, tick, accept, commit, rd_go, ovf_set, unf_set;

  assign count   = w_ptr - r_ptr;
  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign tick    = (div_cnt == DIV_TOP);
  assign accept  = bus.wr & ~full;
  assign commit  = accept & (beat_cnt == LAST_BEAT);
  assign rd_go   = tick & bus.rd & ~empty;
  assign ovf_set = bus.wr & full;
  assign unf_set = tick & bus.rd & empty;
  assign slot    = (BEAT_MSB_FIRST != 0) ? (LAST_BEAT - beat_cnt) : beat_cnt;

  // Merge the current beat into its slice; on the last beat this is the whole entry.
  always_comb begin
    asm_next = asm_q;
    for (int k = 0; k < PACK; k++) begin
      if (slot == BCW'(k)) asm_next[k*IN_W +: IN_W] = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !bus.flush && commit) mem[w_ptr[DEPTH_LOG2-1:0]] <= asm_next;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_ptr      <= '0;
      r_ptr      <= '0;
      beat_cnt   <= '0;
      asm_q      <= '0;
      div_cnt    <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      div_cnt    <= tick ? '0 : div_cnt + 1'b1;
      ovf_q      <= ovf_set | (ovf_q & ~bus.flush);
      unf_q      <= unf_set | (unf_q & ~bus.flush);
      rd_valid_q <= rd_go & ~bus.flush;
      if (bus.flush) begin
        w_ptr    <= '0;
        r_ptr    <= '0;
        beat_cnt <= '0;
        asm_q    <= '0;
      end else begin
        if (accept) begin
          if (commit) begin
            w_ptr    <= w_ptr + 1'b1;
            beat_cnt <= '0;
          end else begin
            asm_q    <= asm_next;
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        if (rd_go) begin
          data_out_q <= mem[r_ptr[DEPTH_LOG2-1:0]];
          r_ptr      <= r_ptr + 1'b1;
        end
      end
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.data_count = count;
  assign bus.partial    = (beat_cnt != '0);
  assign bus.full       = full;
  assign bus.empty      = empty;
  assign bus.threshold  = (count >= THRESH_C);
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
endmodule
